// File: rtl/shiftreg_feeder.sv
// shiftreg_feeder
//
// Paces words from a small FIFO into a parallel-load shift register.
// Each accepted word is issued as a one-cycle load strobe. Consecutive
// strobes are spaced exactly BITS+GAP cycles apart, so the downstream
// shifter finishes one word before the next one is loaded.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   i_data       word to transmit
//   i_vld        i_data valid; accepted on an edge where i_vld && o_rdy
//   o_rdy        FIFO can accept (not full)
//   o_state      parallel word to the shifter; holds the last issued word
//   o_state_vld  one-cycle load strobe
//   o_busy       high for the whole BITS+GAP window of the current word
//   o_level      FIFO occupancy, 0..DEPTH
//
// FSM:
//   state | meaning
//   IDLE  | no word in flight, cnt == 0; waits for a non-empty FIFO
//   ISSUE | load strobe cycle; word popped and registered on entry
//   HOLD  | cnt counts down to 1; the cnt==1 cycle decides the next issue

module shiftreg_feeder #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITS-1:0]        i_data,
    input  logic                   i_vld,
    output logic                   o_rdy,
    output logic [BITS-1:0]        o_state,
    output logic                   o_state_vld,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PERIOD = BITS + GAP;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int CW     = $clog2(PERIOD);

    localparam logic [CW-1:0] CNT_LOAD   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            last_hold;
    logic [BITS-1:0] head;

    assign full      = (count == LEVEL_FULL);
    assign empty     = (count == '0);
    assign o_rdy     = !full;
    assign o_level   = count;
    assign push      = i_vld && !full;
    assign last_hold = (state == HOLD) && (cnt == CNT_LAST);

    // A word arriving in the final HOLD cycle still counts as pending so
    // the strobe train stays gapless. It is written into storage and
    // popped on the same edge; its value is taken from the write data
    // because the storage slot is only written on that edge.
    assign pop  = ((state == IDLE) && !empty) || (last_hold && (!empty || push));
    assign head = empty ? i_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_state     <= '0;
            o_state_vld <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_state_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state       <= ISSUE;
                        o_state     <= head;
                        o_state_vld <= 1'b1;
                        o_busy      <= 1'b1;
                        cnt         <= CNT_LOAD;
                    end
                end
                // cnt stays at its load value here so HOLD spans
                // PERIOD-1 cycles and the whole window is PERIOD cycles.
                ISSUE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == CNT_LAST) begin
                        if (pop) begin
                            state       <= ISSUE;
                            o_state     <= head;
                            o_state_vld <= 1'b1;
                            cnt         <= CNT_LOAD;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            cnt    <= '0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_feeder.sv
// Testbench for shiftreg_feeder: a GAP=0 instance (dut_a) and a GAP=3
// instance (dut_b). Accepted words are queued as expectations; strobes are
// logged by a monitor and compared in order by each scenario task.

module tb_shiftreg_feeder;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] a_in, b_in;
    logic       a_iv, b_iv;
    logic       a_rdy, b_rdy;
    logic [7:0] a_st, b_st;
    logic       a_sv, b_sv;
    logic       a_busy, b_busy;
    logic [2:0] a_lvl, b_lvl;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] sa_val[$];
    logic [7:0] sb_val[$];
    int         sa_cyc[$];
    int         sb_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    shiftreg_feeder #(.BITS(8), .DEPTH(4), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .i_data(a_in), .i_vld(a_iv), .o_rdy(a_rdy),
        .o_state(a_st), .o_state_vld(a_sv), .o_busy(a_busy), .o_level(a_lvl)
    );

    shiftreg_feeder #(.BITS(8), .DEPTH(4), .GAP(3)) dut_b (
        .clk(clk), .rst(rst), .i_data(b_in), .i_vld(b_iv), .o_rdy(b_rdy),
        .o_state(b_st), .o_state_vld(b_sv), .o_busy(b_busy), .o_level(b_lvl)
    );

    always @(negedge clk) begin
        if (a_sv === 1'b1) begin
            sa_val.push_back(a_st);
            sa_cyc.push_back(cyc);
        end
        if (b_sv === 1'b1) begin
            sb_val.push_back(b_st);
            sb_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drives one word and holds it until accepted; acc is the edge number
    // (value of cyc after that edge) at which the push happens.
    task automatic send(input bit sel, input logic [7:0] d, output int acc);
        int guard = 0;
        acc = -1;
        if (sel == 1'b0) begin a_in = d; a_iv = 1'b1; end
        else             begin b_in = d; b_iv = 1'b1; end
        while (acc < 0 && guard < 40) begin
            if (sel == 1'b0 && a_rdy === 1'b1) begin
                acc = cyc + 1;
                exp_a.push_back(d);
            end else if (sel == 1'b1 && b_rdy === 1'b1) begin
                acc = cyc + 1;
                exp_b.push_back(d);
            end
            tick();
            guard++;
        end
        if (sel == 1'b0) a_iv = 1'b0;
        else             b_iv = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL send_accept: word %h not accepted, want accept within 40 cycles", d);
        end
    endtask

    task automatic wait_strobes(input bit sel, input int n, input int limit);
        int guard = 0;
        while (((sel == 1'b0) ? sa_val.size() : sb_val.size()) < n && guard < limit) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (a_st !== 8'h00) begin n_err++; $display("FAIL reset_state: got %h want 00", a_st); end
        n_cmp++; if (a_sv !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", a_sv); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_cmp++; if (a_lvl !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", a_lvl); end
        n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", a_rdy); end
        n_cmp++; if (b_sv !== 1'b0) begin n_err++; $display("FAIL reset_b_vld: got %b want 0", b_sv); end
        n_cmp++; if (b_lvl !== 3'd0) begin n_err++; $display("FAIL reset_b_level: got %0d want 0", b_lvl); end
    endtask

    task automatic test_single(input logic [7:0] d, input string tag);
        int base;
        int acc;
        int busy_cnt = 0;
        logic [7:0] e;
        exp_a.delete();
        base = sa_val.size();
        send(1'b0, d, acc);
        repeat (20) begin
            if (a_busy === 1'b1) busy_cnt++;
            tick();
        end
        n_cmp++;
        if (sa_val.size() - base !== 1) begin
            n_err++; $display("FAIL %s_strobes: got %0d want 1", tag, sa_val.size() - base);
        end
        if (sa_val.size() > base && exp_a.size() > 0) begin
            e = exp_a.pop_front();
            n_cmp++;
            if (sa_val[base] !== e) begin n_err++; $display("FAIL %s_value: got %h want %h", tag, sa_val[base], e); end
            n_cmp++;
            if (sa_cyc[base] !== acc + 1) begin
                n_err++; $display("FAIL %s_latency: strobe cycle %0d want %0d", tag, sa_cyc[base], acc + 1);
            end
        end
        n_cmp++; if (busy_cnt !== 8) begin n_err++; $display("FAIL %s_busy_len: got %0d want 8", tag, busy_cnt); end
        n_cmp++; if (a_lvl !== 3'd0) begin n_err++; $display("FAIL %s_level: got %0d want 0", tag, a_lvl); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL %s_idle: busy %b want 0", tag, a_busy); end
    endtask

    task automatic test_back_to_back();
        int base;
        int acc;
        logic [7:0] e;
        logic [23:0] stream = '0;
        exp_a.delete();
        base = sa_val.size();
        send(1'b0, 8'h81, acc);
        send(1'b0, 8'h3C, acc);
        send(1'b0, 8'hFF, acc);
        wait_strobes(1'b0, base + 3, 60);
        repeat (12) tick();
        n_cmp++;
        if (sa_val.size() - base !== 3) begin n_err++; $display("FAIL b2b_strobes: got %0d want 3", sa_val.size() - base); end
        for (int k = 0; k < 3; k++) begin
            if (base + k < sa_val.size() && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                stream = {stream[15:0], sa_val[base + k]};
                n_cmp++;
                if (sa_val[base + k] !== e) begin n_err++; $display("FAIL b2b_value%0d: got %h want %h", k, sa_val[base + k], e); end
            end
            if (k > 0 && base + k < sa_val.size()) begin
                n_cmp++;
                if (sa_cyc[base + k] - sa_cyc[base + k - 1] !== 8) begin
                    n_err++; $display("FAIL b2b_spacing%0d: got %0d want 8", k, sa_cyc[base + k] - sa_cyc[base + k - 1]);
                end
            end
        end
        n_cmp++;
        if (stream !== 24'h813CFF) begin n_err++; $display("FAIL b2b_stream: got %h want 813cff", stream); end
    endtask

    task automatic test_fill();
        int base;
        int acc;
        logic [7:0] e;
        logic [7:0] words [6];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_a.delete();
        base = sa_val.size();
        for (int k = 0; k < 5; k++) send(1'b0, words[k], acc);
        n_cmp++; if (a_lvl !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d want 4", a_lvl); end
        n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL fill_rdy: got %b want 0", a_rdy); end
        send(1'b0, words[5], acc);
        wait_strobes(1'b0, base + 6, 80);
        repeat (12) tick();
        n_cmp++;
        if (sa_val.size() - base !== 6) begin n_err++; $display("FAIL fill_strobes: got %0d want 6", sa_val.size() - base); end
        for (int k = 0; k < 6; k++) begin
            if (base + k < sa_val.size() && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                n_cmp++;
                if (sa_val[base + k] !== e) begin n_err++; $display("FAIL fill_value%0d: got %h want %h", k, sa_val[base + k], e); end
            end
            if (k > 0 && base + k < sa_val.size()) begin
                n_cmp++;
                if (sa_cyc[base + k] - sa_cyc[base + k - 1] !== 8) begin
                    n_err++; $display("FAIL fill_spacing%0d: got %0d want 8", k, sa_cyc[base + k] - sa_cyc[base + k - 1]);
                end
            end
        end
    endtask

    task automatic test_gap();
        int base;
        int acc;
        int guard = 0;
        int low_cnt = 0;
        logic [7:0] e;
        exp_b.delete();
        base = sb_val.size();
        send(1'b1, 8'hC3, acc);
        send(1'b1, 8'h5A, acc);
        while (sb_val.size() < base + 2 && guard < 60) begin
            if (sb_val.size() == base + 1 && b_busy !== 1'b1) low_cnt++;
            tick();
            guard++;
        end
        repeat (14) tick();
        n_cmp++;
        if (sb_val.size() - base !== 2) begin n_err++; $display("FAIL gap_strobes: got %0d want 2", sb_val.size() - base); end
        for (int k = 0; k < 2; k++) begin
            if (base + k < sb_val.size() && exp_b.size() > 0) begin
                e = exp_b.pop_front();
                n_cmp++;
                if (sb_val[base + k] !== e) begin n_err++; $display("FAIL gap_value%0d: got %h want %h", k, sb_val[base + k], e); end
            end
        end
        if (sb_val.size() >= base + 2) begin
            n_cmp++;
            if (sb_cyc[base + 1] - sb_cyc[base] !== 11) begin
                n_err++; $display("FAIL gap_spacing: got %0d want 11", sb_cyc[base + 1] - sb_cyc[base]);
            end
        end
        n_cmp++; if (low_cnt !== 0) begin n_err++; $display("FAIL gap_busy_low: got %0d cycles want 0", low_cnt); end
        n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL gap_idle: busy %b want 0", b_busy); end
    endtask

    task automatic test_last_hold();
        int base;
        int acc;
        int s0;
        int guard = 0;
        logic [7:0] e;
        exp_a.delete();
        base = sa_val.size();
        send(1'b0, 8'h96, acc);
        wait_strobes(1'b0, base + 1, 10);
        s0 = (sa_val.size() > base) ? sa_cyc[base] : cyc;
        // The cnt==1 cycle of this word is s0+7; push lands on edge s0+8.
        while (cyc < s0 + 7 && guard < 40) begin
            tick();
            guard++;
        end
        send(1'b0, 8'h69, acc);
        n_cmp++;
        if (acc !== s0 + 8) begin n_err++; $display("FAIL lasthold_accept: edge %0d want %0d", acc, s0 + 8); end
        wait_strobes(1'b0, base + 2, 20);
        repeat (12) tick();
        n_cmp++;
        if (sa_val.size() - base !== 2) begin n_err++; $display("FAIL lasthold_strobes: got %0d want 2", sa_val.size() - base); end
        for (int k = 0; k < 2; k++) begin
            if (base + k < sa_val.size() && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                n_cmp++;
                if (sa_val[base + k] !== e) begin n_err++; $display("FAIL lasthold_value%0d: got %h want %h", k, sa_val[base + k], e); end
            end
        end
        if (sa_val.size() >= base + 2) begin
            n_cmp++;
            if (sa_cyc[base + 1] - sa_cyc[base] !== 8) begin
                n_err++; $display("FAIL lasthold_spacing: got %0d want 8", sa_cyc[base + 1] - sa_cyc[base]);
            end
        end
        n_cmp++; if (a_lvl !== 3'd0) begin n_err++; $display("FAIL lasthold_level: got %0d want 0", a_lvl); end
    endtask

    task automatic test_reset_mid();
        int base;
        int acc;
        exp_a.delete();
        send(1'b0, 8'h01, acc);
        send(1'b0, 8'h02, acc);
        send(1'b0, 8'h03, acc);
        send(1'b0, 8'h04, acc);
        n_cmp++; if (a_lvl !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_level: got %0d want 3", a_lvl); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (a_lvl !== 3'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", a_lvl); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        n_cmp++; if (a_sv !== 1'b0) begin n_err++; $display("FAIL rstmid_vld: got %b want 0", a_sv); end
        n_cmp++; if (a_st !== 8'h00) begin n_err++; $display("FAIL rstmid_state: got %h want 00", a_st); end
        n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_rdy: got %b want 1", a_rdy); end
        tick();
        tick();
        exp_a.delete();
        base = sa_val.size();
        rst = 1'b0;
        repeat (15) tick();
        n_cmp++;
        if (sa_val.size() - base !== 0) begin n_err++; $display("FAIL rstmid_spurious: got %0d strobes want 0", sa_val.size() - base); end
        test_single(8'hA5, "post_rst");
    endtask

    initial begin
        rst  = 1'b1;
        a_in = '0; a_iv = 1'b0;
        b_in = '0; b_iv = 1'b0;
        tick();
        test_reset();
        rst = 1'b0;
        repeat (2) tick();
        test_single(8'hA5, "single");
        repeat (4) tick();
        test_back_to_back();
        repeat (4) tick();
        test_fill();
        repeat (4) tick();
        test_gap();
        repeat (4) tick();
        test_last_hold();
        repeat (4) tick();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
